// File: rtl/bt656_line_scheduler_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bt656_line_scheduler_if : write port from the scheduler to the FIFO |
// | Revision 1.0                                                         |
// +--------------------------------------------------------------------+
interface bt656_line_scheduler_if;
  logic       wr_req;
  logic [7:0] wr_data;
  logic       fifo_room;

  modport master (output wr_req, output wr_data, input fifo_room);
  modport slave  (input wr_req, input wr_data, output fifo_room);
endinterface
`default_nettype wire

// File: rtl/bt656_line_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bt656_line_scheduler : BT.656 TRS decode, line admission, Y capture |
// | Optional macro BT656_XY_PROTECT_EN enables XY protection-bit check. |
// | Revision 1.0                                                         |
// +--------------------------------------------------------------------+
module bt656_line_scheduler #(
  parameter int LINE_WIDTH   = 720,
  parameter int ACTIVE_LINES = 288
) (
  input  logic                          bt_clock,
  input  logic                          reset,
  input  logic [7:0]                    bt_data,
  input  logic                          enable,
  bt656_line_scheduler_if.master        fifo,
  output logic                          line_start,
  output logic                          field_start,
  output logic                          field_id,
  output logic [9:0]                    line_num,
  output logic                          locked,
  output logic [7:0]                    drop_count,
  output logic                          trs_err
);

  localparam int              CNT_W     = $clog2(2 * LINE_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(2 * LINE_WIDTH - 1);
  localparam logic [9:0]       LINE_CAP  = 10'(ACTIVE_LINES);

  typedef enum logic [2:0] {
    S_HUNT   = 3'd0,
    S_T1     = 3'd1,
    S_T2     = 3'd2,
    S_XY     = 3'd3,
    S_ACTIVE = 3'd4,
    S_SKIP   = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic             wr_req_q, wr_req_d;
  logic [7:0]       wr_data_q, wr_data_d;
  logic             line_start_q, line_start_d;
  logic             field_start_q, field_start_d;
  logic             field_id_q, field_id_d;
  logic [9:0]       line_num_q, line_num_d;
  logic             locked_q, locked_d;
  logic [7:0]       drop_count_q, drop_count_d;
  logic             trs_err_q, trs_err_d;
  logic             capture_q, capture_d;
  logic             vblank_q, vblank_d;

  logic xy_f, xy_v, xy_h, xy_valid;
  assign xy_f = bt_data[6];
  assign xy_v = bt_data[5];
  assign xy_h = bt_data[4];

`ifdef BT656_XY_PROTECT_EN
  assign xy_valid = bt_data[7] &&
                    (bt_data[3:0] == {xy_v ^ xy_h, xy_f ^ xy_h, xy_f ^ xy_v, xy_f ^ xy_v ^ xy_h});
`else
  assign xy_valid = bt_data[7];
`endif

  always_comb begin
    state_d       = state_q;
    byte_cnt_d    = byte_cnt_q;
    wr_req_d      = 1'b0;
    wr_data_d     = wr_data_q;
    line_start_d  = 1'b0;
    field_start_d = 1'b0;
    field_id_d    = field_id_q;
    line_num_d    = line_num_q;
    locked_d      = locked_q;
    drop_count_d  = drop_count_q;
    trs_err_d     = 1'b0;
    capture_d     = capture_q;
    vblank_d      = vblank_q;

    unique case (state_q)
      S_HUNT: if (bt_data == 8'hFF) state_d = S_T1;
      S_T1:   state_d = (bt_data == 8'h00) ? S_T2 : S_HUNT;
      S_T2:   state_d = (bt_data == 8'h00) ? S_XY : S_HUNT;
      S_XY: begin
        state_d = S_HUNT;
        if (!xy_valid) begin
          trs_err_d = 1'b1;
          locked_d  = 1'b0;
        end else if (xy_v) begin
          vblank_d = 1'b1;
        end else if (!xy_h) begin
          // First active SAV after blanking: lock, and the field starts locked.
          if (vblank_q) begin
            vblank_d      = 1'b0;
            locked_d      = 1'b1;
            field_start_d = 1'b1;
            field_id_d    = xy_f;
            line_num_d    = 10'd0;
            capture_d     = enable;
          end
          byte_cnt_d = '0;
          state_d    = S_SKIP;
          if (locked_d && capture_d) begin
            if (fifo.fifo_room && (line_num_d < LINE_CAP)) begin
              state_d      = S_ACTIVE;
              line_start_d = 1'b1;
            end else if (drop_count_q != 8'hFF) begin
              drop_count_d = drop_count_q + 8'd1;
            end
          end
        end
      end
      S_ACTIVE, S_SKIP: begin
        // A stray FF means the line was cut short; treat it as the next TRS.
        if (bt_data == 8'hFF) begin
          trs_err_d = 1'b1;
          locked_d  = 1'b0;
          state_d   = S_T1;
        end else begin
          wr_req_d   = (state_q == S_ACTIVE) && byte_cnt_q[0];
          if (wr_req_d) wr_data_d = bt_data;
          byte_cnt_d = byte_cnt_q + CNT_W'(1);
          if (byte_cnt_q == LAST_BYTE) begin
            state_d = S_HUNT;
            if (line_num_q < LINE_CAP) line_num_d = line_num_q + 10'd1;
          end
        end
      end
      default: state_d = S_HUNT;
    endcase
  end

  always_ff @(posedge bt_clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_HUNT;
      byte_cnt_q    <= '0;
      wr_req_q      <= 1'b0;
      wr_data_q     <= 8'd0;
      line_start_q  <= 1'b0;
      field_start_q <= 1'b0;
      field_id_q    <= 1'b0;
      line_num_q    <= 10'd0;
      locked_q      <= 1'b0;
      drop_count_q  <= 8'd0;
      trs_err_q     <= 1'b0;
      capture_q     <= 1'b0;
      vblank_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_cnt_q    <= byte_cnt_d;
      wr_req_q      <= wr_req_d;
      wr_data_q     <= wr_data_d;
      line_start_q  <= line_start_d;
      field_start_q <= field_start_d;
      field_id_q    <= field_id_d;
      line_num_q    <= line_num_d;
      locked_q      <= locked_d;
      drop_count_q  <= drop_count_d;
      trs_err_q     <= trs_err_d;
      capture_q     <= capture_d;
      vblank_q      <= vblank_d;
    end
  end

  assign fifo.wr_req  = wr_req_q;
  assign fifo.wr_data = wr_data_q;
  assign line_start   = line_start_q;
  assign field_start  = field_start_q;
  assign field_id     = field_id_q;
  assign line_num     = line_num_q;
  assign locked       = locked_q;
  assign drop_count   = drop_count_q;
  assign trs_err      = trs_err_q;

endmodule
`default_nettype wire

// File: tb/tb_bt656_line_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_bt656_line_scheduler : directed/random bench with line-level model|
// | Revision 1.0                                                         |
// +--------------------------------------------------------------------+
module tb_bt656_line_scheduler;

  localparam int LW = 64;
  localparam int AL = 16;

  logic       bt_clock;
  logic       reset;
  logic [7:0] bt_data;
  logic       enable;
  logic       line_start, field_start, field_id, locked, trs_err;
  logic [9:0] line_num;
  logic [7:0] drop_count;

  bt656_line_scheduler_if fifo_if ();

  bt656_line_scheduler #(.LINE_WIDTH(LW), .ACTIVE_LINES(AL)) dut (
    .bt_clock    (bt_clock),
    .reset       (reset),
    .bt_data     (bt_data),
    .enable      (enable),
    .fifo        (fifo_if),
    .line_start  (line_start),
    .field_start (field_start),
    .field_id    (field_id),
    .line_num    (line_num),
    .locked      (locked),
    .drop_count  (drop_count),
    .trs_err     (trs_err)
  );

  initial bt_clock = 1'b0;
  always #5 bt_clock = ~bt_clock;

  // Monitor: captured writes and pulse counts (owned only by this block)
  logic [7:0] got_q[$];
  int ls_cnt = 0, fs_cnt = 0, te_cnt = 0;
  always @(negedge bt_clock) begin
    if (!reset) begin
      if (fifo_if.wr_req) got_q.push_back(fifo_if.wr_data);
      ls_cnt <= ls_cnt + int'(line_start);
      fs_cnt <= fs_cnt + int'(field_start);
      te_cnt <= te_cnt + int'(trs_err);
    end
  end

  // Line-level reference model
  logic [7:0]  exp_q[$];
  int          chk_idx = 0;
  int          exp_ls = 0, exp_fs = 0, exp_te = 0;
  int unsigned m_line = 0, m_drop = 0;
  bit          m_locked = 0, m_vblank = 0, m_capture = 0, m_field = 0;

  int n_cmp = 0, n_mis = 0;
  logic [31:0] obs_b0, obs_b1, obs_last;
  logic [7:0]  b1_val, last_val;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] mk_xy(input logic f, input logic v, input logic h);
    return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
  endfunction

  function automatic bit xy_ok(input logic [7:0] x);
`ifdef BT656_XY_PROTECT_EN
    return x[7] && (x == mk_xy(x[6], x[5], x[4]));
`else
    return x[7];
`endif
  endfunction

  // mode: 0 = not in a line, 1 = skipped line, 2 = admitted line
  task automatic model_xy(input logic [7:0] x, output int mode);
    mode = 0;
    if (!xy_ok(x)) begin
      m_locked = 0;
      exp_te++;
    end else if (x[5]) begin
      m_vblank = 1;
    end else if (!x[4]) begin
      if (m_vblank) begin
        m_vblank = 0; m_locked = 1; exp_fs++;
        m_field = x[6]; m_line = 0; m_capture = enable;
      end
      mode = 1;
      if (m_locked && m_capture) begin
        if (fifo_if.fifo_room && m_line < AL) begin
          mode = 2; exp_ls++;
        end else if (m_drop < 255) begin
          m_drop++;
        end
      end
    end
  endtask

  task automatic send(input logic [7:0] b);
    bt_data = b;
    @(posedge bt_clock);
    #1;
  endtask

  task automatic send_trs(input logic [7:0] x, output int mode);
    model_xy(x, mode);
    send(8'hFF); send(8'h00); send(8'h00); send(x);
  endtask

  task automatic send_payload(input int mode, input int abort_at);
    logic [7:0] b;
    for (int i = 0; i < 2 * LW; i++) begin
      if (i == abort_at) begin
        send(8'hFF);
        if (mode != 0) begin m_locked = 0; exp_te++; end
        return;
      end
      b = 8'($urandom_range(254, 1));
      fifo_if.fifo_room = 1'($urandom);
      send(b);
      if (mode == 2 && i[0]) exp_q.push_back(b);
      if (i == 0) obs_b0 = 32'(fifo_if.wr_req);
      if (i == 1) begin obs_b1 = 32'({fifo_if.wr_req, fifo_if.wr_data}); b1_val = b; end
      if (i == 2 * LW - 1) begin obs_last = 32'({fifo_if.wr_req, fifo_if.wr_data}); last_val = b; end
    end
    if (mode != 0 && m_line < AL) m_line++;
  endtask

  task automatic do_line(input logic [7:0] x, input logic room);
    int mode, dummy;
    fifo_if.fifo_room = room;
    send_trs(x, mode);
    send_payload(mode, -1);
    send_trs(mk_xy(m_field, 1'b0, 1'b1), dummy);
  endtask

  task automatic check_writes(input string tag);
    int nd = 0;
    check({tag, " write count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = chk_idx; i < exp_q.size() && i < got_q.size(); i++)
      if (got_q[i] !== exp_q[i]) nd++;
    check({tag, " write data diffs"}, 32'(nd), 32'd0);
    chk_idx = exp_q.size();
    check({tag, " line_start pulses"}, 32'(ls_cnt), 32'(exp_ls));
    check({tag, " field_start pulses"}, 32'(fs_cnt), 32'(exp_fs));
    check({tag, " trs_err pulses"}, 32'(te_cnt), 32'(exp_te));
  endtask

  task automatic check_status(input string tag);
    check({tag, " line_num"}, 32'(line_num), 32'(m_line));
    check({tag, " locked"}, 32'(locked), 32'(m_locked));
    check({tag, " drop_count"}, 32'(drop_count), 32'(m_drop));
    check({tag, " field_id"}, 32'(field_id), 32'(m_field));
  endtask

  function automatic logic [31:0] all_outs();
    return {fifo_if.wr_req, fifo_if.wr_data, line_start, field_start, field_id,
            line_num, locked, drop_count, trs_err};
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int mode, dummy;
    logic [7:0] b;

    reset = 1'b1; bt_data = 8'h00; enable = 1'b0; fifo_if.fifo_room = 1'b0;
    repeat (3) @(posedge bt_clock);
    #1;
    check("reset outputs", all_outs(), 32'd0);
    @(negedge bt_clock); reset = 1'b0;
    @(posedge bt_clock); #1;

    // Lock and capture
    enable = 1'b1;
    send_trs(mk_xy(0, 1, 1), dummy);
    send_trs(mk_xy(0, 1, 0), dummy);
    fifo_if.fifo_room = 1'b1;
    send_trs(8'h80, mode);
    check("lock line_start", 32'(line_start), 32'd1);
    check("lock field_start", 32'(field_start), 32'd1);
    check("lock locked", 32'(locked), 32'd1);
    check("lock line_num", 32'(line_num), 32'd0);
    send_payload(mode, -1);
    check("first Cb no write", obs_b0, 32'd0);
    check("first Y write", obs_b1, {23'd0, 1'b1, b1_val});
    check("last Y write", obs_last, {23'd0, 1'b1, last_val});
    send_trs(mk_xy(0, 0, 1), dummy);
    check_writes("lock");
    check_status("lock");

    // FIFO full on the middle line of a new field
    send_trs(mk_xy(1, 1, 0), dummy);
    do_line(mk_xy(1, 0, 0), 1'b1);
    do_line(mk_xy(1, 0, 0), 1'b0);
    do_line(mk_xy(1, 0, 0), 1'b1);
    check_writes("fifo full");
    check_status("fifo full");

    // Capture disabled at field start, enable raised mid-field
    enable = 1'b0;
    send_trs(mk_xy(1, 1, 0), dummy);
    do_line(mk_xy(1, 0, 0), 1'b1);
    enable = 1'b1;
    do_line(mk_xy(1, 0, 0), 1'b0);
    do_line(mk_xy(1, 0, 0), 1'b1);
    check_writes("disabled");
    check_status("disabled");
    send_trs(mk_xy(0, 1, 0), dummy);
    do_line(mk_xy(0, 0, 0), 1'b1);
    check_writes("resume");
    check_status("resume");

    // FF inside an admitted line
    fifo_if.fifo_room = 1'b1;
    send_trs(mk_xy(0, 0, 0), mode);
    send_payload(mode, 100);
    check("abort wr_req", 32'(fifo_if.wr_req), 32'd0);
    check("abort trs_err", 32'(trs_err), 32'd1);
    check("abort locked", 32'(locked), 32'd0);
    model_xy(8'h80, mode);
    send(8'h00); send(8'h00); send(8'h80);
    send_payload(mode, -1);
    send_trs(mk_xy(0, 0, 1), dummy);
    check_writes("abort");
    check_status("abort");

    // XY 81: protection bits wrong
    send_trs(mk_xy(0, 1, 0), dummy);
    do_line(8'h80, 1'b1);
    do_line(8'h81, 1'b1);
    check_writes("xy81");
    check_status("xy81");

    // Drop counter saturation and active-line limit
    send_trs(mk_xy(1, 1, 0), dummy);
    for (int i = 0; i < 300; i++) begin
      do_line(mk_xy(1, 0, 0), 1'b0);
      if (i == 199) check("drop midway", 32'(drop_count), 32'(m_drop));
    end
    check("drop saturated", 32'(drop_count), 32'd255);
    check("line_num capped", 32'(line_num), 32'(AL));
    check_writes("saturate");
    check_status("saturate");

    // Asynchronous reset in the middle of an admitted line
    send_trs(mk_xy(0, 1, 0), dummy);
    fifo_if.fifo_room = 1'b1;
    send_trs(mk_xy(0, 0, 0), mode);
    for (int k = 0; k < 22; k++) begin
      b = 8'($urandom_range(254, 1));
      send(b);
      if (k[0] && k < 21) exp_q.push_back(b);
    end
    check("pre-reset strobe", 32'(fifo_if.wr_req), 32'd1);
    #1 reset = 1'b1;
    #1 check("async reset outputs", all_outs(), 32'd0);
    m_line = 0; m_drop = 0; m_locked = 0; m_vblank = 0; m_capture = 0; m_field = 0;
    check_writes("reset");
    repeat (2) @(posedge bt_clock);
    @(negedge bt_clock); reset = 1'b0;
    @(posedge bt_clock); #1;
    send_trs(mk_xy(0, 1, 0), dummy);
    do_line(mk_xy(0, 0, 0), 1'b1);
    check_writes("post reset");
    check_status("post reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
